// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 active-low matrix keypad scanner with full-scan
// debouncing. It produces the accepted key code, a one-cycle accept pulse, a
// held flag, and a display code that shows 4'hF until the first key is accepted.
module keypad_scan_debounce #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] disp_code
);
    localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
    typedef enum logic {RELEASED, PRESSED} state_t;

    // Key index is {row, col}.
    function automatic logic [3:0] key_lut(input logic [3:0] idx);
        case (idx)
            4'd0:  key_lut = 4'h1;
            4'd1:  key_lut = 4'h2;
            4'd2:  key_lut = 4'h3;
            4'd3:  key_lut = 4'hA;
            4'd4:  key_lut = 4'h4;
            4'd5:  key_lut = 4'h5;
            4'd6:  key_lut = 4'h6;
            4'd7:  key_lut = 4'hB;
            4'd8:  key_lut = 4'h7;
            4'd9:  key_lut = 4'h8;
            4'd10: key_lut = 4'h9;
            4'd11: key_lut = 4'hC;
            4'd12: key_lut = 4'hE;
            4'd13: key_lut = 4'h0;
            4'd14: key_lut = 4'hF;
            default: key_lut = 4'hD;
        endcase
    endfunction

    logic [3:0]    row_meta, row_sync;
    logic [TW-1:0] tick;
    logic [1:0]    col_idx;
    logic [15:0]   acc, scan_now;
    logic          tick_last, eval;
    res_t          res_kind, prev_kind;
    logic [3:0]    res_code, prev_code;
    logic [SW-1:0] stable_cnt, stable_nx;
    logic          stable_hit;
    state_t        state, state_nx;
    logic [3:0]    code_nx;
    logic          valid_nx, seen, seen_nx;

    assign tick_last = (tick == TICK_LAST);
    assign eval      = tick_last && (col_idx == 2'd3);
    assign col_n     = ~(4'b0001 << col_idx);

    // Two-flop synchronizer for the asynchronous rows; cleared to "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Current scan image with the active column's synchronized rows merged in.
    always_comb begin
        scan_now = acc;
        for (int unsigned r = 0; r < 4; r++) begin
            scan_now[{r[1:0], col_idx}] = ~row_sync[r];
        end
    end

    // Column dwell counter, column stepping and row sampling at end of dwell.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick    <= '0;
            col_idx <= '0;
            acc     <= '0;
        end else if (tick_last) begin
            tick    <= '0;
            col_idx <= col_idx + 2'd1;
            acc     <= scan_now;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Classify the completed scan as none / single key / multiple keys.
    always_comb begin
        res_kind = RES_NONE;
        res_code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (scan_now[i]) begin
                if (res_kind == RES_NONE) begin
                    res_kind = RES_KEY;
                    res_code = key_lut(4'(i));
                end else begin
                    res_kind = RES_MULTI;
                end
            end
        end
        if (res_kind == RES_MULTI) res_code = '0;
    end

    // Next stable count: MULTI clears it, repeats count up to saturation.
    always_comb begin
        stable_nx = SW'(1);
        if (res_kind == RES_MULTI) begin
            stable_nx = '0;
        end else if ((res_kind == prev_kind) && (res_code == prev_code)) begin
            stable_nx = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
        end
        stable_hit = eval && (stable_nx == STABLE_MAX) && (res_kind != RES_MULTI);
    end

    // Remember the previous scan result and its repeat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_kind  <= RES_NONE;
            prev_code  <= '0;
            stable_cnt <= '0;
        end else if (eval) begin
            prev_kind  <= res_kind;
            prev_code  <= res_code;
            stable_cnt <= stable_nx;
        end
    end

    // FSM state and registered key outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RELEASED;
            key_code  <= '0;
            key_valid <= 1'b0;
            seen      <= 1'b0;
        end else begin
            state     <= state_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            seen      <= seen_nx;
        end
    end

    // FSM next state: accept stable presses and rollovers, drop on stable release.
    always_comb begin
        state_nx = state;
        code_nx  = key_code;
        valid_nx = 1'b0;
        seen_nx  = seen;
        if (stable_hit) begin
            case (state)
                RELEASED: begin
                    if (res_kind == RES_KEY) begin
                        state_nx = PRESSED;
                        code_nx  = res_code;
                        valid_nx = 1'b1;
                        seen_nx  = 1'b1;
                    end
                end
                PRESSED: begin
                    if (res_kind == RES_NONE) begin
                        state_nx = RELEASED;
                    end else if (res_code != key_code) begin
                        code_nx  = res_code;
                        valid_nx = 1'b1;
                    end
                end
            endcase
        end
    end

    // FSM outputs: held flag and display code.
    always_comb begin
        key_held  = (state == PRESSED);
        disp_code = seen ? key_code : 4'hF;
    end
endmodule
